mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the single-port RAM and the
// mem_port_arbiter. The arbiter connects through the slave modport; the
// requester/RAM side (pipeline or bench) uses the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  // load/store port
  logic              mem_req;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic              mem_se;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  // RAM side
  logic              ram_en;
  logic              ram_rw;
  logic [1:0]        ram_size;
  logic              ram_se;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  // pipeline control
  logic              pc_le;
  logic              if_id_le;
  logic              pipe_stall;

  modport slave (
    input  if_req, if_addr, mem_req, mem_rw, mem_size, mem_se, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_rw, ram_size, ram_se,
           ram_addr, ram_wdata, pc_le, if_id_le, pipe_stall
  );

  modport master (
    output if_req, if_addr, mem_req, mem_rw, mem_size, mem_se, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, ram_en, ram_rw, ram_size, ram_se,
           ram_addr, ram_wdata, pc_le, if_id_le, pipe_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the fetch port and the
// load/store port. Each access holds ram_en for MEM_LAT cycles, then the
// granted port gets a one-cycle ack with its read data.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration when both
// ports request together; without it MEM always wins.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic               Clk,
  input logic               Clr,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_grant_mem, w_grant_mem_next;
  logic              r_ram_en, w_ram_en_next;
  logic              r_ram_rw, w_ram_rw_next;
  logic [1:0]        r_ram_size, w_ram_size_next;
  logic              r_ram_se, w_ram_se_next;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
  logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_next;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_next;
  logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_next;
  logic              r_if_ack, w_if_ack_next;
  logic              r_mem_ack, w_mem_ack_next;
  logic              w_pick_mem, w_pick_if;
  logic              w_stall;

`ifdef MEM_ARB_RR_EN
  logic r_last_mem;

  // Round-robin pick: on a tie the port that did not win last time goes first
  always_comb begin
    w_pick_mem = bus.mem_req & ~(bus.if_req & r_last_mem);
    w_pick_if  = bus.if_req & ~(bus.mem_req & ~r_last_mem);
  end

  // Remember the winner of every grant made in IDLE
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_last_mem <= 1'b0;
    end else if ((r_state == ST_IDLE) && (w_pick_mem || w_pick_if)) begin
      r_last_mem <= w_pick_mem;
    end
  end
`else
  // Fixed priority pick: the load/store port always wins a tie
  always_comb begin
    w_pick_mem = bus.mem_req;
    w_pick_if  = bus.if_req & ~bus.mem_req;
  end
`endif

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_grant_mem_next = r_grant_mem;
    w_ram_en_next    = r_ram_en;
    w_ram_rw_next    = r_ram_rw;
    w_ram_size_next  = r_ram_size;
    w_ram_se_next    = r_ram_se;
    w_ram_addr_next  = r_ram_addr;
    w_ram_wdata_next = r_ram_wdata;
    w_if_rdata_next  = r_if_rdata;
    w_mem_rdata_next = r_mem_rdata;
    w_if_ack_next    = 1'b0;
    w_mem_ack_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_mem || w_pick_if) begin
          w_state_next     = ST_BUSY;
          w_cnt_next       = CNT_INIT;
          w_grant_mem_next = w_pick_mem;
          w_ram_en_next    = 1'b1;
          if (w_pick_mem) begin
            w_ram_rw_next    = bus.mem_rw;
            w_ram_size_next  = bus.mem_size;
            w_ram_se_next    = bus.mem_se;
            w_ram_addr_next  = bus.mem_addr;
            w_ram_wdata_next = bus.mem_wdata;
          end else begin
            // fetches are always aligned word reads
            w_ram_rw_next    = 1'b0;
            w_ram_size_next  = 2'b10;
            w_ram_se_next    = 1'b0;
            w_ram_addr_next  = bus.if_addr;
            w_ram_wdata_next = '0;
          end
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_state_next  = ST_DONE;
          w_ram_en_next = 1'b0;
          if (r_grant_mem) begin
            w_mem_ack_next   = 1'b1;
            w_mem_rdata_next = r_ram_rw ? '0 : bus.ram_rdata;
          end else begin
            w_if_ack_next   = 1'b1;
            w_if_rdata_next = bus.ram_rdata;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_grant_mem <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_rw    <= 1'b0;
      r_ram_size  <= 2'b00;
      r_ram_se    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_grant_mem <= w_grant_mem_next;
      r_ram_en    <= w_ram_en_next;
      r_ram_rw    <= w_ram_rw_next;
      r_ram_size  <= w_ram_size_next;
      r_ram_se    <= w_ram_se_next;
      r_ram_addr  <= w_ram_addr_next;
      r_ram_wdata <= w_ram_wdata_next;
      r_if_rdata  <= w_if_rdata_next;
      r_mem_rdata <= w_mem_rdata_next;
      r_if_ack    <= w_if_ack_next;
      r_mem_ack   <= w_mem_ack_next;
    end
  end

  // A pending load/store freezes the back half of the pipeline; a fetch acked
  // while that stall is active is thrown away and the fetch is re-issued.
  assign w_stall        = bus.mem_req & ~r_mem_ack;
  assign bus.pipe_stall = w_stall;
  assign bus.pc_le      = r_if_ack & ~w_stall;
  assign bus.if_id_le   = r_if_ack & ~w_stall;

  assign bus.ram_en    = r_ram_en;
  assign bus.ram_rw    = r_ram_rw;
  assign bus.ram_size  = r_ram_size;
  assign bus.ram_se    = r_ram_se;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_ack   = r_mem_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level timing model
// (grant edge, busy window, ack edge). A second instance with MEM_LAT=1
// covers the single-cycle latency case.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;

  logic Clk = 1'b0;
  logic Clr = 1'b1;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) u_dut_a (
    .Clk(Clk), .Clr(Clr), .bus(bus_a)
  );
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) u_dut_b (
    .Clk(Clk), .Clr(Clr), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state for instance A
  int                edge_n    = 0;
  int                next_free = 0;
  bit                m_active  = 0;
  int                m_gedge   = 0;
  bit                m_gmem    = 0;
  bit                m_last_mem = 0;
  logic              m_rw      = 0;
  logic [1:0]        m_size    = 0;
  logic              m_se      = 0;
  logic [ADDR_W-1:0] m_addr    = 0;
  logic [DATA_W-1:0] m_wdata   = 0;
  logic [DATA_W-1:0] m_if_rdata  = 0;
  logic [DATA_W-1:0] m_mem_rdata = 0;
  bit                e_if_ack  = 0;
  bit                e_mem_ack = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h edge=%0d", tag, act, exp, edge_n - 1);
    end
  endtask

  // Advance the model over the upcoming rising edge using the inputs now applied
  task automatic model_edge();
    if (Clr) begin
      m_active = 0; next_free = edge_n + 1; m_last_mem = 0;
      m_rw = 0; m_size = 0; m_se = 0; m_addr = 0; m_wdata = 0;
      m_if_rdata = 0; m_mem_rdata = 0;
    end else begin
      if (m_active && (edge_n == m_gedge + LAT)) begin
        if (m_gmem) m_mem_rdata = m_rw ? '0 : bus_a.ram_rdata;
        else        m_if_rdata  = bus_a.ram_rdata;
      end
      if ((edge_n >= next_free) && (bus_a.mem_req || bus_a.if_req)) begin
        bit take_mem;
`ifdef MEM_ARB_RR_EN
        take_mem = (bus_a.mem_req && bus_a.if_req) ? !m_last_mem : bus_a.mem_req;
`else
        take_mem = bus_a.mem_req;
`endif
        m_last_mem = take_mem;
        m_active   = 1;
        m_gedge    = edge_n;
        m_gmem     = take_mem;
        next_free  = edge_n + LAT + 2;
        if (take_mem) begin
          m_rw = bus_a.mem_rw; m_size = bus_a.mem_size; m_se = bus_a.mem_se;
          m_addr = bus_a.mem_addr; m_wdata = bus_a.mem_wdata;
        end else begin
          m_rw = 0; m_size = 2'b10; m_se = 0; m_addr = bus_a.if_addr; m_wdata = 0;
        end
      end
    end
    edge_n++;
  endtask

  task automatic check_outputs();
    int  le;
    bit  e_en;
    bit  e_stall;
    le        = edge_n - 1;
    e_en      = m_active && (le >= m_gedge) && (le < m_gedge + LAT);
    e_if_ack  = m_active && !m_gmem && (le == m_gedge + LAT);
    e_mem_ack = m_active && m_gmem && (le == m_gedge + LAT);
    e_stall   = bus_a.mem_req && !e_mem_ack;
    check_val("ram_en",     64'(bus_a.ram_en),     64'(e_en));
    check_val("ram_rw",     64'(bus_a.ram_rw),     64'(m_rw));
    check_val("ram_size",   64'(bus_a.ram_size),   64'(m_size));
    check_val("ram_se",     64'(bus_a.ram_se),     64'(m_se));
    check_val("ram_addr",   64'(bus_a.ram_addr),   64'(m_addr));
    check_val("ram_wdata",  64'(bus_a.ram_wdata),  64'(m_wdata));
    check_val("if_ack",     64'(bus_a.if_ack),     64'(e_if_ack));
    check_val("if_rdata",   64'(bus_a.if_rdata),   64'(m_if_rdata));
    check_val("mem_ack",    64'(bus_a.mem_ack),    64'(e_mem_ack));
    check_val("mem_rdata",  64'(bus_a.mem_rdata),  64'(m_mem_rdata));
    check_val("pipe_stall", 64'(bus_a.pipe_stall), 64'(e_stall));
    check_val("pc_le",      64'(bus_a.pc_le),      64'(e_if_ack && !e_stall));
    check_val("if_id_le",   64'(bus_a.if_id_le),   64'(e_if_ack && !e_stall));
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    @(negedge Clk);
    check_outputs();
  endtask

  initial begin
    int if_ack_cnt;
    int en_rise_cnt;
    bit prev_en;
    bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.mem_req = 0; bus_a.mem_rw = 0;
    bus_a.mem_size = 0; bus_a.mem_se = 0; bus_a.mem_addr = 0; bus_a.mem_wdata = 0;
    bus_a.ram_rdata = 0;
    bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.mem_req = 0; bus_b.mem_rw = 0;
    bus_b.mem_size = 0; bus_b.mem_se = 0; bus_b.mem_addr = 0; bus_b.mem_wdata = 0;
    bus_b.ram_rdata = 0;
    @(negedge Clk);

    // reset
    Clr = 1;
    step(); step();
    check_val("rst_b_ram_en", 64'(bus_b.ram_en), 64'd0);
    check_val("rst_b_ack",    64'(bus_b.mem_ack), 64'd0);
    Clr = 0;
    step();

    // 1: plain fetch
    bus_a.if_req = 1; bus_a.if_addr = 9'h010; bus_a.ram_rdata = 32'hDEADBEEF;
    step();
    check_val("t1_en_c1",   64'(bus_a.ram_en),   64'd1);
    check_val("t1_addr",    64'(bus_a.ram_addr), 64'h010);
    check_val("t1_size",    64'(bus_a.ram_size), 64'd2);
    step();
    check_val("t1_en_c2",   64'(bus_a.ram_en),   64'd1);
    step();
    check_val("t1_ack",     64'(bus_a.if_ack),   64'd1);
    check_val("t1_rdata",   64'(bus_a.if_rdata), 64'hDEADBEEF);
    check_val("t1_pc_le",   64'(bus_a.pc_le),    64'd1);
    bus_a.if_req = 0;
    step();
    check_val("t1_ack_off", 64'(bus_a.if_ack),   64'd0);

    // 2: simultaneous requests, MEM served first
    bus_a.mem_req = 1; bus_a.mem_rw = 0; bus_a.mem_size = 2'b10; bus_a.mem_addr = 9'h100;
    bus_a.if_req = 1; bus_a.if_addr = 9'h020;
    step();
    check_val("t2_mem_first", 64'(bus_a.ram_addr),   64'h100);
    check_val("t2_stall",     64'(bus_a.pipe_stall), 64'd1);
    step();
    bus_a.ram_rdata = 32'hCAFEF00D;
    step();
    check_val("t2_mem_ack",   64'(bus_a.mem_ack),    64'd1);
    check_val("t2_mem_rdata", 64'(bus_a.mem_rdata),  64'hCAFEF00D);
    check_val("t2_stall_off", 64'(bus_a.pipe_stall), 64'd0);
    bus_a.mem_req = 0;
    step();
    step();
    check_val("t2_if_grant",  64'(bus_a.ram_addr),   64'h020);
    step(); step();
    check_val("t2_if_ack",    64'(bus_a.if_ack),     64'd1);
    bus_a.if_req = 0;
    step();

    // 3: halfword store
    bus_a.mem_req = 1; bus_a.mem_rw = 1; bus_a.mem_size = 2'b01;
    bus_a.mem_addr = 9'h1F0; bus_a.mem_wdata = 32'h0000ABCD;
    step();
    check_val("t3_rw",    64'(bus_a.ram_rw),    64'd1);
    check_val("t3_size",  64'(bus_a.ram_size),  64'd1);
    check_val("t3_wdata", 64'(bus_a.ram_wdata), 64'h0000ABCD);
    step(); step();
    check_val("t3_ack",   64'(bus_a.mem_ack),   64'd1);
    check_val("t3_rdata", 64'(bus_a.mem_rdata), 64'd0);
    bus_a.mem_req = 0; bus_a.mem_rw = 0;
    step();

    // 4: reset during the first busy cycle aborts the access
    bus_a.if_req = 1; bus_a.if_addr = 9'h030;
    step();
    Clr = 1;
    step();
    check_val("t4_en_off", 64'(bus_a.ram_en),   64'd0);
    check_val("t4_addr0",  64'(bus_a.ram_addr), 64'd0);
    Clr = 0;
    step();
    check_val("t4_regrant", 64'(bus_a.ram_addr), 64'h030);
    step(); step();
    check_val("t4_ack",    64'(bus_a.if_ack),   64'd1);
    bus_a.if_req = 0;
    step();

    // 5: fetch request held for 12 edges -> exactly three accesses
    if_ack_cnt = 0; en_rise_cnt = 0; prev_en = 0;
    bus_a.if_req = 1; bus_a.if_addr = 9'h040;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus_a.if_ack) if_ack_cnt++;
      if (bus_a.ram_en && !prev_en) en_rise_cnt++;
      prev_en = bus_a.ram_en;
    end
    bus_a.if_req = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_a.if_ack) if_ack_cnt++;
      if (bus_a.ram_en && !prev_en) en_rise_cnt++;
      prev_en = bus_a.ram_en;
    end
    check_val("t5_acks",   64'(if_ack_cnt),  64'd3);
    check_val("t5_grants", 64'(en_rise_cnt), 64'd3);

    // 6: MEM_LAT=1 instance, word load
    bus_b.mem_req = 1; bus_b.mem_rw = 0; bus_b.mem_size = 2'b10; bus_b.mem_addr = 9'h004;
    step();
    check_val("t6_en",    64'(bus_b.ram_en),   64'd1);
    check_val("t6_addr",  64'(bus_b.ram_addr), 64'h004);
    bus_b.ram_rdata = 32'h12345678;
    step();
    check_val("t6_en_off", 64'(bus_b.ram_en),    64'd0);
    check_val("t6_ack",    64'(bus_b.mem_ack),   64'd1);
    check_val("t6_rdata",  64'(bus_b.mem_rdata), 64'h12345678);
    bus_b.mem_req = 0;
    step();
    check_val("t6_ack_off", 64'(bus_b.mem_ack),  64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      Clr = ($urandom_range(0, 99) == 0);
      if (!bus_a.mem_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus_a.mem_req   = 1;
          bus_a.mem_rw    = 1'($urandom_range(0, 1));
          bus_a.mem_size  = 2'($urandom_range(0, 2));
          bus_a.mem_se    = 1'($urandom_range(0, 1));
          bus_a.mem_addr  = 9'($urandom);
          bus_a.mem_wdata = $urandom;
        end
      end else if (e_mem_ack || ($urandom_range(0, 39) == 0)) begin
        bus_a.mem_req = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        bus_a.mem_addr  = 9'($urandom);
        bus_a.mem_wdata = $urandom;
      end
      if (!bus_a.if_req) begin
        if ($urandom_range(0, 1) == 0) begin
          bus_a.if_req  = 1;
          bus_a.if_addr = 9'($urandom);
        end
      end else if (e_if_ack || ($urandom_range(0, 39) == 0)) begin
        bus_a.if_req = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        bus_a.if_addr = 9'($urandom);
      end
      bus_a.ram_rdata = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
